// File: rtl/decoder_frame_ctrl_if.sv
// Handshake and data bundle between the frame controller and its neighbours.
// The slave modport is the controller's view of the bundle; the master modport is its environment's view.
interface decoder_frame_ctrl_if #(
    parameter int WIDTH_IN  = 8,
    parameter int N_LLRS    = 4,
    parameter int WIDTH_OUT = 8,
    parameter int N_V       = 31,
    parameter int CNT_W     = 8
);
    logic [N_LLRS*WIDTH_IN-1:0] in_data;
    logic                       in_first;
    logic                       in_valid;
    logic                       in_ready;
    logic [N_V*WIDTH_IN-1:0]    core_llrs;
    logic                       core_start;
    logic                       core_done;
    logic [N_V-1:0]             core_cw;
    logic [WIDTH_OUT-1:0]       out_data;
    logic                       out_valid;
    logic                       out_first;
    logic                       out_last;
    logic                       out_ready;
    logic                       busy;
    logic [CNT_W-1:0]           frame_cnt;
    logic [CNT_W-1:0]           err_cnt;

    modport master (
        output in_data, in_first, in_valid, core_done, core_cw, out_ready,
        input  in_ready, core_llrs, core_start, out_data, out_valid, out_first, out_last,
               busy, frame_cnt, err_cnt
    );

    modport slave (
        input  in_data, in_first, in_valid, core_done, core_cw, out_ready,
        output in_ready, core_llrs, core_start, out_data, out_valid, out_first, out_last,
               busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/decoder_frame_ctrl.sv
// Frame I/O controller: assembles an LLR frame, runs the core handshake, streams the codeword out.
// DEC_HARD_BYPASS_EN: skip the core and emit hard decisions (LLR sign bits) as the codeword.
module decoder_frame_ctrl #(
    parameter int WIDTH_IN  = 8,
    parameter int N_LLRS    = 4,
    parameter int WIDTH_OUT = 8,
    parameter int N_V       = 31,
    parameter int CNT_W     = 8
) (
    input logic                 clk,
    input logic                 rst,
    decoder_frame_ctrl_if.slave bus
);
    localparam int IN_BEATS  = (N_V - 1) / N_LLRS + 1;
    localparam int FIRST_IN  = (N_V - 1) % N_LLRS + 1;
    localparam int OUT_BEATS = (N_V - 1) / WIDTH_OUT + 1;
    localparam int FRAME_W   = N_V * WIDTH_IN;
    localparam int BEAT_W    = N_LLRS * WIDTH_IN;
    localparam int SR_W      = OUT_BEATS * WIDTH_OUT;
    localparam int IB_W      = $clog2(IN_BEATS + 1);
    localparam int OB_W      = $clog2(OUT_BEATS + 1);
`ifdef DEC_HARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SEND} state_t;

    state_t            state, state_nx;
    logic              alive;
    logic [FRAME_W-1:0] frame;
    logic [SR_W-1:0]   out_sr;
    logic [SR_W-1:0]   cw_ext;
    logic [N_V-1:0]    cw_src;
    logic [IB_W-1:0]   in_cnt;
    logic [OB_W-1:0]   out_cnt;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              in_ready, out_valid, core_start;
    logic              accept, first_acc, last_in, out_acc, last_out, capture;

    assign in_ready  = alive && (state == IDLE || state == LOAD);
    assign out_valid = (state == SEND);
    assign accept    = bus.in_valid && in_ready;
    assign first_acc = accept && bus.in_first;
    assign last_in   = (in_cnt == IB_W'(IN_BEATS - 1));
    assign out_acc   = out_valid && bus.out_ready;
    assign last_out  = (out_cnt == OB_W'(OUT_BEATS - 1));

`ifdef DEC_HARD_BYPASS_EN
    logic unused_core;
    assign unused_core = ^{bus.core_done, bus.core_cw};
    assign capture     = (state == START);
    always_comb begin
        cw_src = '0;
        for (int unsigned i = 0; i < N_V; i++) begin
            cw_src[i] = frame[i*WIDTH_IN + WIDTH_IN - 1];
        end
    end
`else
    assign capture = (state == WAIT) && bus.core_done;
    assign cw_src  = bus.core_cw;
`endif

    // Codeword is right-aligned in the shift register so the first beat carries the zero padding.
    always_comb begin
        cw_ext            = '0;
        cw_ext[N_V-1:0]   = cw_src;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        core_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (first_acc) state_nx = (IN_BEATS == 1) ? START : LOAD;
            end
            LOAD: begin
                if (first_acc)               state_nx = (IN_BEATS == 1) ? START : LOAD;
                else if (accept && last_in)  state_nx = START;
            end
            START: begin
                core_start = !BYPASS;
                state_nx   = BYPASS ? SEND : WAIT;
            end
            WAIT: begin
                if (capture) state_nx = SEND;
            end
            SEND: begin
                if (out_acc && last_out) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive     <= 1'b0;
            frame     <= '0;
            in_cnt    <= '0;
            out_sr    <= '0;
            out_cnt   <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            alive <= 1'b1;
            // A first beat always restarts assembly; in LOAD it also counts as an error.
            if (first_acc) begin
                frame  <= FRAME_W'(bus.in_data[FIRST_IN*WIDTH_IN-1:0]);
                in_cnt <= IB_W'(1);
                if (state == LOAD && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end else if (accept && state == LOAD) begin
                frame  <= (frame << BEAT_W) | FRAME_W'(bus.in_data);
                in_cnt <= in_cnt + 1'b1;
            end
            if (capture) begin
                out_sr  <= cw_ext;
                out_cnt <= '0;
            end else if (out_acc) begin
                out_sr  <= out_sr << WIDTH_OUT;
                out_cnt <= out_cnt + 1'b1;
                if (last_out) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.core_llrs  = frame;
    assign bus.core_start = core_start;
    assign bus.out_data   = out_sr[SR_W-1 -: WIDTH_OUT];
    assign bus.out_valid  = out_valid;
    assign bus.out_first  = out_valid && (out_cnt == '0);
    assign bus.out_last   = out_valid && last_out;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_cnt  = frame_cnt;
    assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_decoder_frame_ctrl.sv
// Self-checking bench for decoder_frame_ctrl at default parameters (core or hard-bypass build).
module tb_decoder_frame_ctrl;
    localparam int WIDTH_IN  = 8;
    localparam int N_LLRS    = 4;
    localparam int WIDTH_OUT = 8;
    localparam int N_V       = 31;
    localparam int CNT_W     = 8;
    localparam int IN_BEATS  = 8;
    localparam int FIRST_IN  = 3;
    localparam int OUT_BEATS = 4;
`ifdef DEC_HARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef logic [WIDTH_IN-1:0] llr_arr_t [N_V];
    typedef struct {
        logic [7:0]     base;
        logic [7:0]     step;
        logic [N_V-1:0] cw;
        int unsigned    delay;
        int unsigned    rmode;
        logic [31:0]    exp_core;
        logic [31:0]    exp_byp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decoder_frame_ctrl_if #(.WIDTH_IN(WIDTH_IN), .N_LLRS(N_LLRS), .WIDTH_OUT(WIDTH_OUT),
                            .N_V(N_V), .CNT_W(CNT_W)) bus ();
    decoder_frame_ctrl #(.WIDTH_IN(WIDTH_IN), .N_LLRS(N_LLRS), .WIDTH_OUT(WIDTH_OUT),
                         .N_V(N_V), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned start_pulses = 0;
    int unsigned exp_frames = 0;
    int unsigned exp_errs = 0;

    always @(posedge clk) if (bus.core_start === 1'b1) start_pulses++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat 0 carries the top FIRST_IN LLRs; later beats walk down the frame, last beat = LLRs 0..N_LLRS-1.
    function automatic logic [N_LLRS*WIDTH_IN-1:0] beat_data(input llr_arr_t llr, input int b);
        logic [N_LLRS*WIDTH_IN-1:0] d;
        d = $urandom;
        for (int j = 0; j < N_LLRS; j++) begin
            if (b == 0) begin
                if (j < FIRST_IN) d[j*WIDTH_IN +: WIDTH_IN] = llr[N_V-FIRST_IN+j];
            end else begin
                d[j*WIDTH_IN +: WIDTH_IN] = llr[N_V-FIRST_IN-b*N_LLRS+j];
            end
        end
        return d;
    endfunction

    function automatic logic [N_V*WIDTH_IN-1:0] frame_of(input llr_arr_t llr);
        logic [N_V*WIDTH_IN-1:0] f;
        for (int i = 0; i < N_V; i++) f[i*WIDTH_IN +: WIDTH_IN] = llr[i];
        return f;
    endfunction

    function automatic logic [N_V-1:0] hard_cw(input llr_arr_t llr);
        logic [N_V-1:0] c;
        for (int i = 0; i < N_V; i++) c[i] = llr[i][WIDTH_IN-1];
        return c;
    endfunction

    // Output bit stream: leading zero padding, then codeword MSB first; beat 0 in the top byte.
    function automatic logic [31:0] model_stream(input logic [N_V-1:0] cw);
        bit q[$];
        logic [31:0] s;
        for (int i = 0; i < OUT_BEATS*WIDTH_OUT - N_V; i++) q.push_back(1'b0);
        for (int i = N_V - 1; i >= 0; i--) q.push_back(cw[i]);
        for (int k = 0; k < OUT_BEATS*WIDTH_OUT; k++) s[OUT_BEATS*WIDTH_OUT-1-k] = q[k];
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_core_start", bus.core_start, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_first", bus.out_first, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_core_llrs", bus.core_llrs, '0);
        chk("rst_frame_cnt", bus.frame_cnt, '0);
        chk("rst_err_cnt", bus.err_cnt, '0);
        tick();
        tick();
        rst = 1'b0;
        chk("rel_in_ready_before_clk", bus.in_ready, 1'b0);
        tick();
        chk("rel_in_ready_after_clk", bus.in_ready, 1'b1);
        exp_frames = 0;
        exp_errs   = 0;
    endtask

    task automatic load_partial(input llr_arr_t llr, input int n);
        for (int b = 0; b < n; b++) begin
            bus.in_data  = beat_data(llr, b);
            bus.in_first = (b == 0);
            bus.in_valid = 1'b1;
            bus.core_done = (b == 1);
            bus.core_cw   = $urandom;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.core_done = 1'b0;
        chk("partial_busy", bus.busy, 1'b1);
    endtask

    // rmode: 0 out_ready always, 1 pattern 1,0,0, 2 random. abort_after>=0 stops mid-SEND.
    task automatic run_frame(input llr_arr_t llr, input logic [N_V-1:0] cw, input int unsigned delay,
                             input int unsigned rmode, input bit gaps, input logic [31:0] exp_stream,
                             input int abort_after);
        int unsigned p0, beat, cyc;
        bit r;
        logic [N_V*WIDTH_IN-1:0] exp_frame;
        exp_frame = frame_of(llr);
        p0 = start_pulses;
        for (int b = 0; b < IN_BEATS; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_first = 1'($urandom_range(0, 1));
                    bus.in_data  = $urandom;
                    tick();
                end
            end
            bus.in_data  = beat_data(llr, b);
            bus.in_first = (b == 0);
            bus.in_valid = 1'b1;
            chk("in_ready_load", bus.in_ready, 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        chk("core_start", bus.core_start, !BYPASS);
        chk("in_ready_start", bus.in_ready, 1'b0);
        chk("busy_start", bus.busy, 1'b1);
        chk("core_llrs", bus.core_llrs, exp_frame);
        tick();
        if (!BYPASS) begin
            chk("core_start_wait", bus.core_start, 1'b0);
            repeat (delay) begin
                chk("out_valid_wait", bus.out_valid, 1'b0);
                tick();
            end
            bus.core_done = 1'b1;
            bus.core_cw   = cw;
            tick();
            bus.core_done = 1'b0;
            bus.core_cw   = $urandom;
        end
        beat = 0;
        cyc  = 0;
        while (beat < OUT_BEATS && cyc < 100 && !(abort_after >= 0 && beat == abort_after)) begin
            chk("out_valid", bus.out_valid, 1'b1);
            chk("out_data", bus.out_data, exp_stream[(OUT_BEATS-1-beat)*WIDTH_OUT +: WIDTH_OUT]);
            chk("out_first", bus.out_first, beat == 0);
            chk("out_last", bus.out_last, beat == OUT_BEATS - 1);
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = r;
            tick();
            cyc++;
            if (r) beat++;
        end
        bus.out_ready = 1'b0;
        if (abort_after >= 0) return;
        chk("out_beat_budget", beat, OUT_BEATS);
        exp_frames++;
        chk("idle_out_valid", bus.out_valid, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_in_ready", bus.in_ready, 1'b1);
        chk("frame_cnt", bus.frame_cnt, CNT_W'(exp_frames));
        chk("err_cnt", bus.err_cnt, CNT_W'(exp_errs));
        chk("core_llrs_hold", bus.core_llrs, exp_frame);
        chk("core_start_pulses", start_pulses - p0, BYPASS ? 0 : 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vec [4];
        llr_arr_t llr, llr_b;
        logic [N_V-1:0] cw;
        logic [31:0] stream;

        vec[0] = '{8'h00, 8'h01, 31'h55555555, 10, 0, 32'h55555555, 32'h00000000};
        vec[1] = '{8'h80, 8'h00, 31'h7FFFFFFF, 0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF};
        vec[2] = '{8'h3C, 8'h01, 31'h12345678, 3, 1, 32'h12345678, 32'h00000000};
        vec[3] = '{8'hF0, 8'h01, 31'h40000001, 1, 0, 32'h40000001, 32'h0000FFFF};

        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.core_done = 1'b0;
        bus.core_cw   = '0;
        bus.out_ready = 1'b0;
        #2;
        do_reset();

        // Non-first beats in IDLE are dropped; stray core_done is ignored.
        for (int c = 0; c < 5; c++) begin
            bus.in_data   = $urandom;
            bus.in_first  = 1'b0;
            bus.in_valid  = 1'b1;
            bus.core_done = (c == 2);
            tick();
            chk("idle_drop_busy", bus.busy, 1'b0);
            chk("idle_drop_ready", bus.in_ready, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.core_done = 1'b0;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < N_V; i++) llr[i] = WIDTH_IN'(vec[v].base + vec[v].step * i);
            stream = BYPASS ? vec[v].exp_byp : vec[v].exp_core;
            run_frame(llr, vec[v].cw, vec[v].delay, vec[v].rmode, 1'b0, stream, -1);
        end

        // Restart at beat 5: old frame discarded, error counted.
        for (int i = 0; i < N_V; i++) llr[i] = $urandom;
        for (int i = 0; i < N_V; i++) llr_b[i] = WIDTH_IN'(8'hA5 ^ i);
        cw = 31'h2AAA0F0F;
        load_partial(llr, 5);
        chk("err_before_restart", bus.err_cnt, CNT_W'(exp_errs));
        exp_errs++;
        run_frame(llr_b, cw, 4, 0, 1'b0, model_stream(BYPASS ? hard_cw(llr_b) : cw), -1);

        // Reset mid-SEND after two accepted beats, then a clean frame.
        for (int i = 0; i < N_V; i++) llr[i] = $urandom;
        cw = 31'h1234ABCD;
        run_frame(llr, cw, 2, 0, 1'b0, model_stream(BYPASS ? hard_cw(llr) : cw), 2);
        do_reset();
        run_frame(llr, cw, 2, 0, 1'b0, model_stream(BYPASS ? hard_cw(llr) : cw), -1);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N_V; i++) llr[i] = $urandom;
            cw = N_V'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N_V; i++) llr_b[i] = $urandom;
                load_partial(llr_b, $urandom_range(1, IN_BEATS - 1));
                exp_errs++;
            end
            run_frame(llr, cw, $urandom_range(0, 12), 2, 1'b1,
                      model_stream(BYPASS ? hard_cw(llr) : cw), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decoder_frame_ctrl.md
# decoder_frame_ctrl

Parametrised frame I/O controller for the min-sum decoder datapath.
- Input side: accepts channel LLRs in multi-beat chunks and assembles one frame of N_V LLRs.
- Core side: hands the frame to the decoding core over a start/done handshake and captures the decoded codeword.
- Output side: streams the codeword out in WIDTH_OUT-bit beats with full ready/valid backpressure.
- Beyond the fixed-timing loader it replaces, it adds input ready, output backpressure, mid-frame restart on a new first beat, and frame/error counters.

## Interface
Parameters:
- WIDTH_IN, 8, bits per LLR (two's complement)
- N_LLRS, 4, LLRs per input beat
- WIDTH_OUT, 8, codeword bits per output beat
- N_V, 31, variable nodes (LLRs / codeword bits per frame)
- CNT_W, 8, width of frame_cnt and err_cnt

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset; all state returns to reset values immediately
- in_data  in  N_LLRS*WIDTH_IN  LLR beat
- in_first  in  1  marks first beat of a frame
- in_valid  in  1  beat valid
- in_ready  out  1  controller accepts beat
- core_llrs  out  N_V*WIDTH_IN  assembled frame, LLR i at bits [i*WIDTH_IN +: WIDTH_IN]
- core_start  out  1  one-cycle start pulse
- core_done  in  1  core result valid (single-cycle pulse)
- core_cw  in  N_V  decoded codeword, sampled on core_done
- out_data  out  WIDTH_OUT  codeword beat
- out_valid / out_first / out_last  out  1 each  beat valid, first beat, last beat
- out_ready  in  1  downstream accepts beat
- busy  out  1  state != IDLE
- frame_cnt  out  CNT_W  frames fully sent, wraps
- err_cnt  out  CNT_W  mid-frame restarts, saturates at all-ones

## Operation
- Derived values: IN_BEATS = (N_V-1)/N_LLRS+1; FIRST_IN = (N_V-1)%N_LLRS+1 LLRs; OUT_BEATS = (N_V-1)/WIDTH_OUT+1; FIRST_OUT = (N_V-1)%WIDTH_OUT+1 bits.
- Input accept: in_valid && in_ready.
- States IDLE, LOAD, START, WAIT, SEND.
- IDLE:
  - in_ready=1.
  - An accepted beat with in_first=1 writes in_data[FIRST_IN*WIDTH_IN-1:0] into the low end of the frame register and sets beat count to 1.
  - Next state is START if IN_BEATS==1, otherwise LOAD.
  - Accepted beats with in_first=0 are discarded.
- LOAD:
  - in_ready=1.
  - An accepted beat shifts the frame register left by N_LLRS*WIDTH_IN and writes in_data into the low bits.
  - When the IN_BEATS-th beat is accepted, go to START.
  - An accepted beat with in_first=1 is a restart: the frame is handled as in IDLE (beat count=1) and err_cnt increments.
  - The first beat's LLRs therefore end up at the highest indices.
- START: core_start=1 for exactly one cycle, then WAIT. core_llrs holds constant from START until the next IDLE.
- WAIT: core_done=1 captures core_cw into the output shift register, then SEND. in_ready=0 in START, WAIT and SEND.
- SEND:
  - Beat 0: out_data = {zeros, cw[N_V-1 -: FIRST_OUT]}, with zeros in the MSBs.
  - Each later beat: out_data = next WIDTH_OUT bits, MSB first.
  - out_first=1 on beat 0; out_last=1 on beat OUT_BEATS-1.
  - On out_valid && out_ready: shift and advance.
  - After the last beat is accepted: frame_cnt+1, go to IDLE.
  - When out_ready=0, out_data and the flags hold stable.
- Reset values:
  - in_ready=0, core_start=0, out_valid=0, out_first=0, out_last=0, busy=0.
  - out_data=0, core_llrs=0, frame_cnt=0, err_cnt=0, state=IDLE.
  - in_ready goes to 1 on the first clk after rst falls.

## Timing
- A frame is accepted in IN_BEATS cycles when in_valid is held high.
- core_start is asserted in the cycle after the last input beat is accepted.
- out_valid rises in the cycle after core_done is sampled.
- Output takes OUT_BEATS cycles with out_ready held high. No bubble between output beats.
- IDLE is re-entered in the cycle after the last accept. The next in_first beat can be accepted in that IDLE cycle.
- core_done outside WAIT is ignored.
- Reset mid-frame or mid-SEND aborts with no partial output; frame_cnt and err_cnt clear.

## Configuration
- DEC_HARD_BYPASS_EN defined:
  - The core is bypassed. START captures hard decisions, cw[i] = sign bit of LLR i, and goes straight to SEND (no WAIT).
  - core_start stays 0 and core_done/core_cw are ignored.
- DEC_HARD_BYPASS_EN undefined: core handshake exactly as in Operation.
- Ports are identical in both builds.

## Test plan
(defaults: 8 in beats, first beat 3 LLRs; 4 out beats, first beat 7 bits)
- Bypass build, all LLRs 8'h80 -> out beats 0x7F, 0xFF, 0xFF, 0xFF; out_first on beat 0, out_last on beat 3; frame_cnt=1.
- Core build, core_done after 10 cycles with core_cw=31'h55555555 -> core_start pulses once; out beats 0x55 x4; core_llrs matches the loaded order (first beat at LLR indices 30..28).
- out_ready toggled 1,0,0,1,... during SEND -> data and flags held while stalled; beat sequence unchanged; 4 accepts total.
- in_first reasserted at beat 5 of a load -> err_cnt=1; the frame completes 8 beats after the restart; output reflects only the new frame.
- rst pulsed mid-SEND after 2 beats -> out_valid=0 immediately; counters=0; in_ready=1 one cycle after release; a following full frame is processed normally.
- Beats with in_first=0 in IDLE -> dropped, busy stays 0; two back-to-back frames -> frame_cnt=2.
